// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// The default timeout is derived from a 100 MHz clock and a 9600-baud 11-bit frame.
package uart_pkg;
  localparam int UART_BYTE_W  = 8;
  localparam int CLK_HZ       = 100_000_000;
  localparam int BAUD         = 9600;
  localparam int FRAME_BITS   = 11;
  localparam int FRAME_CYCLES = (CLK_HZ / BAUD) * FRAME_BITS;
  // ~17 frames of slack, rounded up to a 100k-cycle boundary (2,000,000 at 100 MHz)
  localparam int TIMEOUT_DEFAULT = ((FRAME_CYCLES * 17 + 99_999) / 100_000) * 100_000;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_DONE,
    GAP
  } tx_state_e;
endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Synchronous FIFO with registered count; first-word-fall-through read port.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // storage is not reset; only pointers and count define validity
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// Transmit buffer and sequencer feeding the UART driver: one byte per send,
// next byte only after a rising edge of tx_done_flag, a timeout, and an optional gap.
module uart_tx_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH          = 16,
  parameter int GAP_CYCLES     = 0,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [UART_BYTE_W-1:0]   wr_data,
  input  logic                     ovf_clr,
  input  logic                     tx_done_flag,
  output logic                     send,
  output logic [UART_BYTE_W-1:0]   data_transmit,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy,
  output logic                     overflow,
  output logic                     timeout
);
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int GW = $clog2(GAP_CYCLES + 1) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  tx_state_e              state_q, state_d;
  logic [1:0]             rst_sync;
  logic                   srst_n;
  logic                   done_q, done_rise;
  logic                   pop, tmo_hit;
  logic [TW-1:0]          tmo_cnt;
  logic [GW-1:0]          gap_cnt;
  logic [UART_BYTE_W-1:0] pop_data;

  // asserts with rst_n, releases two clocks later on a clean edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign srst_n = rst_sync[1];

  sync_fifo #(.WIDTH(UART_BYTE_W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (srst_n),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  assign done_rise = tx_done_flag & ~done_q;
  assign send      = (state_q == SEND);
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    tmo_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = SEND;
        end
      end
      SEND: state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (done_rise) begin
          state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
        end else if (tmo_cnt == TMO_LAST) begin
          tmo_hit = 1'b1;
          state_d = IDLE;
        end
      end
      GAP: if (gap_cnt == GAP_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      state_q       <= IDLE;
      done_q        <= 1'b0;
      data_transmit <= '0;
      tmo_cnt       <= '0;
      gap_cnt       <= '0;
      overflow      <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= tx_done_flag;
      if (pop) data_transmit <= pop_data;
      if (state_q == SEND)           tmo_cnt <= '0;
      else if (state_q == WAIT_DONE) tmo_cnt <= tmo_cnt + TW'(1);
      if (state_q == GAP) gap_cnt <= gap_cnt + GW'(1);
      else                gap_cnt <= '0;
      // a new event in the same cycle as the clear wins
      overflow <= (wr_en & full) | (overflow & ~ovf_clr);
      timeout  <= tmo_hit | (timeout & ~ovf_clr);
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Directed bench: u0 (no gap, long timeout) and u1 (GAP_CYCLES=4, TIMEOUT_CYCLES=64).
module tb_uart_tx_fifo_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en0, ovf_clr0, done0, send0, full0, empty0, busy0, ovf0, tmo0;
  logic [7:0] wr_data0, dt0;
  logic [4:0] count0;
  logic       wr_en1, ovf_clr1, done1, send1, full1, empty1, busy1, ovf1, tmo1;
  logic [7:0] wr_data1, dt1;
  logic [4:0] count1;

  int checks = 0;
  int failures = 0;
  int n_send0 = 0;
  int n_send1 = 0;

  always #5 clk = ~clk;

  uart_tx_fifo_ctrl #(.DEPTH(16), .GAP_CYCLES(0), .TIMEOUT_CYCLES(2048)) u0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en0), .wr_data(wr_data0), .ovf_clr(ovf_clr0),
    .tx_done_flag(done0), .send(send0), .data_transmit(dt0), .full(full0), .empty(empty0),
    .count(count0), .busy(busy0), .overflow(ovf0), .timeout(tmo0));

  uart_tx_fifo_ctrl #(.DEPTH(16), .GAP_CYCLES(4), .TIMEOUT_CYCLES(64)) u1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en1), .wr_data(wr_data1), .ovf_clr(ovf_clr1),
    .tx_done_flag(done1), .send(send1), .data_transmit(dt1), .full(full1), .empty(empty1),
    .count(count1), .busy(busy1), .overflow(ovf1), .timeout(tmo1));

  always @(posedge clk) begin
    if (send0 === 1'b1) n_send0 <= n_send0 + 1;
    if (send1 === 1'b1) n_send1 <= n_send1 + 1;
  end

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       clr;
    int         cnt;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       send;
    logic       busy;
  } vec_t;

  vec_t tbl[22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // returns with ok=1 in the first cycle where send is seen (current cycle included)
  task automatic wait_send(input int which, input int max, output int cyc, output bit ok);
    cyc = 0;
    ok  = (which == 0) ? send0 : send1;
    while (!ok && cyc < max) begin
      tick();
      cyc++;
      ok = (which == 0) ? send0 : send1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, base, bad;
    bit ok;
    rst_n = 1'b0;
    wr_en0 = 0; wr_data0 = 0; ovf_clr0 = 0; done0 = 0;
    wr_en1 = 0; wr_data1 = 0; ovf_clr1 = 0; done1 = 0;

    tbl[0] = '{1'b1, 8'hA5, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int k = 1; k <= 16; k++)
      tbl[1+k] = '{1'b1, 8'(k), 1'b0, k, (k == 16), 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[18] = '{1'b1, 8'h11, 1'b0, 16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[19] = '{1'b0, 8'h00, 1'b1, 16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[20] = '{1'b1, 8'h12, 1'b1, 16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[21] = '{1'b0, 8'h00, 1'b1, 16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    repeat (3) tick();
    chk("rst_dt", dt0, 8'h00);
    chk("rst_full", full0, 1'b0);
    chk("rst_ovf", ovf0, 1'b0);
    chk("rst_tmo", tmo0, 1'b0);
    rst_n = 1'b1;

    // idle after reset with no writes
    for (int c = 0; c < 100; c++) begin
      tick();
      if (c % 20 == 19) begin
        chk("idle_empty", empty0, 1'b1);
        chk("idle_count", count0, 0);
        chk("idle_send", send0, 1'b0);
        chk("idle_busy", busy0, 1'b0);
      end
    end

    // single byte, done 500 cycles after send
    base = n_send0;
    wr_en0 = 1; wr_data0 = 8'h55;
    tick();
    wr_en0 = 0;
    chk("w55_send_c1", send0, 1'b0);
    chk("w55_count", count0, 1);
    tick();
    chk("w55_send_c2", send0, 1'b1);
    chk("w55_dt", dt0, 8'h55);
    bad = 0;
    for (int c = 0; c < 500; c++) begin
      tick();
      if (dt0 !== 8'h55 || busy0 !== 1'b1 || send0 !== 1'b0) bad++;
    end
    chk("w55_hold", bad, 0);
    done0 = 1;
    tick();
    chk("w55_idle_after", busy0, 1'b0);
    repeat (2) tick();
    done0 = 0;
    repeat (20) tick();
    chk("w55_one_send", n_send0 - base, 1);

    // table: A5 goes in flight, then 0x01..0x10 fill the FIFO, overflow and clear
    base = n_send0;
    for (int i = 0; i < 22; i++) begin
      wr_en0 = tbl[i].wr; wr_data0 = tbl[i].d; ovf_clr0 = tbl[i].clr;
      tick();
      chk($sformatf("tbl%0d_count", i), count0, tbl[i].cnt);
      chk($sformatf("tbl%0d_full", i), full0, tbl[i].full);
      chk($sformatf("tbl%0d_empty", i), empty0, tbl[i].empty);
      chk($sformatf("tbl%0d_ovf", i), ovf0, tbl[i].ovf);
      chk($sformatf("tbl%0d_send", i), send0, tbl[i].send);
      chk($sformatf("tbl%0d_busy", i), busy0, tbl[i].busy);
      if (i > 0) chk($sformatf("tbl%0d_dt", i), dt0, 8'hA5);
    end
    wr_en0 = 0; ovf_clr0 = 0;

    // drain: each done rise releases the next byte two cycles later, in order
    done0 = 1;
    for (int k = 1; k <= 16; k++) begin
      wait_send(0, 40, cyc, ok);
      chk($sformatf("drain%0d_seen", k), ok, 1'b1);
      chk($sformatf("drain%0d_lat", k), cyc, 2);
      chk($sformatf("drain%0d_byte", k), dt0, 8'(k));
      done0 = 0;
      repeat (20) tick();
      done0 = 1;
    end
    repeat (3) tick();
    done0 = 0;
    chk("drain_empty", empty0, 1'b1);
    chk("drain_busy", busy0, 1'b0);
    chk("drain_total_sends", n_send0 - base, 17);

    // level-held done with gap: one send per byte, next send 6 cycles after the rise
    base = n_send1;
    wr_en1 = 1; wr_data1 = 8'h21;
    tick();
    wr_data1 = 8'h22;
    tick();
    wr_en1 = 0;
    wait_send(1, 10, cyc, ok);
    chk("gap_first_seen", ok, 1'b1);
    chk("gap_first_byte", dt1, 8'h21);
    repeat (10) tick();
    done1 = 1;
    wait_send(1, 20, cyc, ok);
    chk("gap_second_seen", ok, 1'b1);
    chk("gap_second_lat", cyc, 6);
    chk("gap_second_byte", dt1, 8'h22);
    repeat (44) tick();
    chk("gap_held_sends", n_send1 - base, 2);
    done1 = 0;
    repeat (5) tick();
    done1 = 1;
    tick();
    chk("gap_in_gap_busy", busy1, 1'b1);
    repeat (8) tick();
    done1 = 0;
    chk("gap_end_busy", busy1, 1'b0);
    chk("gap_total_sends", n_send1 - base, 2);
    chk("gap_no_tmo", tmo1, 1'b0);

    // done never comes: timeout after 64 WAIT_DONE cycles, next byte proceeds
    wr_en1 = 1; wr_data1 = 8'h31;
    tick();
    wr_data1 = 8'h32;
    tick();
    wr_en1 = 0;
    wait_send(1, 10, cyc, ok);
    chk("tmo_first_seen", ok, 1'b1);
    chk("tmo_first_byte", dt1, 8'h31);
    repeat (64) tick();
    chk("tmo_not_yet", tmo1, 1'b0);
    chk("tmo_still_busy", busy1, 1'b1);
    tick();
    chk("tmo_set", tmo1, 1'b1);
    chk("tmo_idle", busy1, 1'b0);
    tick();
    chk("tmo_next_send", send1, 1'b1);
    chk("tmo_next_byte", dt1, 8'h32);
    ovf_clr1 = 1;
    tick();
    ovf_clr1 = 0;
    chk("tmo_cleared", tmo1, 1'b0);
    done1 = 1;
    repeat (8) tick();
    done1 = 0;
    chk("tmo_done_idle", busy1, 1'b0);

    // reset while waiting for done with 5 entries queued
    wr_en0 = 1;
    for (int i = 0; i < 6; i++) begin
      wr_data0 = 8'(8'h40 + i);
      tick();
    end
    wr_en0 = 0;
    chk("rstm_count", count0, 5);
    chk("rstm_busy", busy0, 1'b1);
    repeat (3) tick();
    #3;
    rst_n = 1'b0;
    #1;
    chk("rstm_count0", count0, 0);
    chk("rstm_empty", empty0, 1'b1);
    chk("rstm_send", send0, 1'b0);
    chk("rstm_idle", busy0, 1'b0);
    base = n_send0;
    tick();
    rst_n = 1'b1;
    repeat (30) tick();
    chk("rstm_no_send", n_send0 - base, 0);
    chk("rstm_still_empty", empty0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo_ctrl.md
Name: uart_tx_fifo_ctrl

Overview:
Transmit-side buffer and sequencer that sits directly upstream of the UART driver's transmitter. It accepts bytes from system logic into a FIFO and pops them one at a time. For each byte it drives the driver's send/data_transmit inputs, then waits for the driver's tx_done_flag before releasing the next byte. It decouples bursty producers (command decoders, status reporters) from the fixed 9600-baud serial rate.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2.
GAP_CYCLES, 0, idle clk cycles inserted between bytes after each done; 0 means no gap.
TIMEOUT_CYCLES, 2000000, maximum clk cycles spent in WAIT_DONE before the byte is abandoned.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
wr_en  in  1  write strobe; pushes wr_data when not full.
wr_data  in  8  byte to enqueue.
ovf_clr  in  1  clears the sticky overflow and timeout flags.
tx_done_flag  in  1  from driver; byte transmitted.
send  out  1  to driver; one-cycle start pulse.
data_transmit  out  8  to driver; byte under transmission, held stable from send until done.
full  out  1  count == DEPTH.
empty  out  1  count == 0.
count  out  $clog2(DEPTH)+1  number of entries stored.
busy  out  1  high in any state other than IDLE.
overflow  out  1  sticky; set when a write is attempted while full.
timeout  out  1  sticky; set when a WAIT_DONE timeout occurs.

Behaviour:
- Reset (async assert, sync release): all outputs 0 except empty=1. Pointers, count, gap and timeout counters cleared. State is IDLE.
- FIFO:
  - Write accepted when wr_en && !full. Pop is internal, in IDLE only, when !empty.
  - Write and pop in the same cycle: count is unchanged and both pointers advance. A pop from a 1-entry FIFO with a simultaneous write is legal and does not set overflow.
  - wr_en while full: data dropped, overflow=1 next cycle. overflow persists until ovf_clr. If ovf_clr and a new overflow occur in the same cycle, set wins.
  - Pointers wrap modulo DEPTH.
- Edge detect: done_rise = tx_done_flag && !done_q, where done_q is tx_done_flag registered. This guards against a level-held done flag.
- FSM states: IDLE, SEND, WAIT_DONE, GAP.
  - IDLE: if !empty, pop the head into data_transmit (registered) and go to SEND. Latency from the first write into an empty FIFO to send=1 is 2 cycles.
  - SEND: send=1 for exactly this one cycle; clear the timeout counter; go to WAIT_DONE.
  - WAIT_DONE: on done_rise, go to GAP if GAP_CYCLES>0, else IDLE. Otherwise increment the timeout counter. When it reaches TIMEOUT_CYCLES-1: set timeout=1 and go to IDLE. The byte is lost and the next byte proceeds.
  - GAP: count GAP_CYCLES cycles, then go to IDLE.
- A done_rise outside WAIT_DONE is ignored.
- data_transmit holds its last value until the next pop; it is never changed while in SEND or WAIT_DONE.
- Reset mid-transmission: the FIFO is flushed and send drops immediately. The driver is reset by the same rst_n.
- Back-to-back bytes with GAP_CYCLES=0: send pulses are separated by at least the serial frame time plus 2 cycles (done_rise→IDLE→SEND).

Decomposition:
- Shared package uart_pkg:
  - State enum (IDLE/SEND/WAIT_DONE/GAP).
  - UART_BYTE_W=8.
  - Default TIMEOUT_CYCLES, derived from the clock frequency and a 9600-baud, 11-bit (odd-parity) frame with margin.
- One natural sub-module, sync_fifo: parameterised width/depth with push/pop/full/empty/count. The controller FSM is instantiated around it.

Test Plan:
- Reset with no writes -> empty=1, count=0, send=0, busy=0 for 100 cycles.
- Write 0x55 into an empty FIFO; model done 500 cycles after send -> send pulses once, 2 cycles after the write. data_transmit=0x55 is held until done. busy=0 afterwards.
- Burst-write 0x01..0x10 (DEPTH=16) back-to-back, then 0x11 -> full=1, 0x11 dropped, overflow=1. The serial order observed is 0x01..0x10. ovf_clr clears overflow.
- tx_done_flag held high for 50 cycles per byte, GAP_CYCLES=4 -> exactly one send per byte. The next send comes 4+2 cycles after the done rising edge.
- Done never returns with TIMEOUT_CYCLES=64 -> timeout=1 after 64 cycles in WAIT_DONE; the next queued byte is sent.
- Assert rst_n=0 during WAIT_DONE with 5 entries queued -> count=0, empty=1, send=0, state IDLE immediately; no send after release.
